// File: rtl/inv_quan_pipe.sv
// Three-stage elastic inverse quantizer: codeword table lookup, log-domain
// scale-factor add, then antilog into the registered DQ output.
module inv_quan_pipe (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  I,
  input  logic [12:0] Y,
  input  logic [1:0]  RATE,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] DQ
);

  // Returns {DQS, DQLN}; the index folds the magnitude bits of negative codewords.
  function automatic logic [12:0] lookup(input logic [1:0] rate, input logic [4:0] code);
    logic [3:0]  idx4;
    logic [2:0]  idx3;
    logic [1:0]  idx2;
    logic        idx1;
    logic [11:0] dqln;
    logic        dqs;
    idx4 = code[4] ? ~code[3:0] : code[3:0];
    idx3 = code[3] ? ~code[2:0] : code[2:0];
    idx2 = code[2] ? ~code[1:0] : code[1:0];
    idx1 = code[1] ? ~code[0]   : code[0];
    dqln = 12'd0;
    dqs  = 1'b0;
    case (rate)
      2'd0: begin
        dqs = code[4];
        case (idx4)
          4'd0:  dqln = 12'd2048;
          4'd1:  dqln = 12'd4030;
          4'd2:  dqln = 12'd28;
          4'd3:  dqln = 12'd104;
          4'd4:  dqln = 12'd169;
          4'd5:  dqln = 12'd224;
          4'd6:  dqln = 12'd274;
          4'd7:  dqln = 12'd318;
          4'd8:  dqln = 12'd358;
          4'd9:  dqln = 12'd395;
          4'd10: dqln = 12'd429;
          4'd11: dqln = 12'd459;
          4'd12: dqln = 12'd488;
          4'd13: dqln = 12'd514;
          4'd14: dqln = 12'd539;
          default: dqln = 12'd566;
        endcase
      end
      2'd1: begin
        dqs = code[3];
        case (idx3)
          3'd0: dqln = 12'd2048;
          3'd1: dqln = 12'd4;
          3'd2: dqln = 12'd135;
          3'd3: dqln = 12'd213;
          3'd4: dqln = 12'd273;
          3'd5: dqln = 12'd323;
          3'd6: dqln = 12'd373;
          default: dqln = 12'd425;
        endcase
      end
      2'd2: begin
        dqs = code[2];
        case (idx2)
          2'd0: dqln = 12'd2048;
          2'd1: dqln = 12'd135;
          2'd2: dqln = 12'd273;
          default: dqln = 12'd373;
        endcase
      end
      default: begin
        dqs  = code[1];
        dqln = idx1 ? 12'd365 : 12'd116;
      end
    endcase
    lookup = {dqs, dqln};
  endfunction

  // Shifting {DQT,8'b0} right by 15-DEX equals (DQT<<7)>>(14-DEX) and stays defined at DEX=15.
  function automatic logic [14:0] antilog(input logic [11:0] dql);
    logic [7:0]  dqt;
    logic [15:0] wide;
    dqt  = {1'b1, dql[6:0]};
    wide = {dqt, 8'b0} >> (4'd15 - dql[10:7]);
    if (dql[11]) antilog = 15'd0;
    else         antilog = wide[14:0];
  endfunction

  logic        s1_vld_q, s1_vld_d, s1_dqs_q, s1_dqs_d;
  logic [11:0] s1_dqln_q, s1_dqln_d;
  logic [10:0] s1_y_q, s1_y_d;
  logic        s2_vld_q, s2_vld_d, s2_dqs_q, s2_dqs_d;
  logic [11:0] s2_dql_q, s2_dql_d;
  logic        s3_vld_q, s3_vld_d;
  logic [15:0] dq_q, dq_d;
  logic        s1_rdy_s, s2_rdy_s, s3_rdy_s;
  logic        unused_y_s;

  assign unused_y_s = ^Y[1:0];

  assign s3_rdy_s  = ~s3_vld_q | out_ready;
  assign s2_rdy_s  = ~s2_vld_q | s3_rdy_s;
  assign s1_rdy_s  = ~s1_vld_q | s2_rdy_s;
  assign in_ready  = s1_rdy_s;
  assign out_valid = s3_vld_q;
  assign DQ        = dq_q;

  // Next-state for every stage: a stage reloads only when it can hand off or is empty.
  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_dqs_d  = s1_dqs_q;
    s1_dqln_d = s1_dqln_q;
    s1_y_d    = s1_y_q;
    s2_vld_d  = s2_vld_q;
    s2_dqs_d  = s2_dqs_q;
    s2_dql_d  = s2_dql_q;
    s3_vld_d  = s3_vld_q;
    dq_d      = dq_q;
    if (s1_rdy_s) begin
      s1_vld_d = in_valid;
      if (in_valid) begin
        {s1_dqs_d, s1_dqln_d} = lookup(RATE, I);
        s1_y_d = Y[12:2];
      end else begin
        s1_y_d = s1_y_q;
      end
    end else begin
      s1_vld_d = s1_vld_q;
    end
    if (s2_rdy_s) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_dqs_d = s1_dqs_q;
        s2_dql_d = s1_dqln_q + {1'b0, s1_y_q};
      end else begin
        s2_dql_d = s2_dql_q;
      end
    end else begin
      s2_vld_d = s2_vld_q;
    end
    if (s3_rdy_s) begin
      s3_vld_d = s2_vld_q;
      if (s2_vld_q) dq_d = {s2_dqs_q, antilog(s2_dql_q)};
      else          dq_d = dq_q;
    end else begin
      s3_vld_d = s3_vld_q;
    end
  end

  // Pipeline registers; reset empties every stage and clears DQ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld_q  <= 1'b0;
      s1_dqs_q  <= 1'b0;
      s1_dqln_q <= 12'd0;
      s1_y_q    <= 11'd0;
      s2_vld_q  <= 1'b0;
      s2_dqs_q  <= 1'b0;
      s2_dql_q  <= 12'd0;
      s3_vld_q  <= 1'b0;
      dq_q      <= 16'h0000;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_dqs_q  <= s1_dqs_d;
      s1_dqln_q <= s1_dqln_d;
      s1_y_q    <= s1_y_d;
      s2_vld_q  <= s2_vld_d;
      s2_dqs_q  <= s2_dqs_d;
      s2_dql_q  <= s2_dql_d;
      s3_vld_q  <= s3_vld_d;
      dq_q      <= dq_d;
    end
  end

endmodule

// File: doc/inv_quan_pipe.md
INV_QUAN_PIPE -- requirements
Module: inv_quan_pipe

Interface
REQ-001 The block SHALL have clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have reset, input, 1 bit, an asynchronous active-high reset.
REQ-003 The block SHALL have in_valid, input, 1 bit, meaning an input codeword is offered.
REQ-004 The block SHALL have in_ready, output, 1 bit, meaning the block accepts the offered codeword this cycle.
REQ-005 The block SHALL have I, input, 5 bits, the ADPCM codeword, LSB-aligned; unused upper bits are ignored.
REQ-006 The block SHALL have Y, input, 13 bits, the quantizer scale factor, unsigned.
REQ-007 The block SHALL have RATE, input, 2 bits, encoded as 0=40, 1=32, 2=24, 3=16 kbit/s.
REQ-008 The block SHALL have out_valid, output, 1 bit, meaning DQ holds a valid result.
REQ-009 The block SHALL have out_ready, input, 1 bit, the downstream accept.
REQ-010 The block SHALL have DQ, output, 16 bits, the quantized difference in sign-magnitude form: bit 15 is the sign, bits 14:0 are the magnitude.

Function
REQ-011 A transfer SHALL occur on a rising edge where both valid and its ready are high; I, Y and RATE SHALL be captured together at the input transfer.
REQ-012 The block SHALL be a 3-stage elastic pipeline: S1 table lookup, S2 log-domain add, S3 antilog and output register.
REQ-013 With out_ready held high, DQ SHALL appear with out_valid high exactly 3 cycles after the input transfer.
REQ-014 Throughput SHALL be one sample per cycle.
REQ-015 Each stage SHALL advance when it is empty or the next stage advances in the same cycle.
REQ-016 in_ready SHALL be a combinational function of S1 occupancy and downstream advance only; it SHALL NOT depend on in_valid.
REQ-017 While out_valid is high and out_ready is low, DQ SHALL hold stable and no sample SHALL be dropped, duplicated or reordered.
REQ-018 S1 SHALL produce DQLN (12 bits) and DQS according to RATE as follows.
- 40k: index = I[4] ? ~I[3:0] : I[3:0]; the table is 2048, 4030, 28, 104, 169, 224, 274, 318, 358, 395, 429, 459, 488, 514, 539, 566; DQS = I[4].
- 32k: index = I[3] ? ~I[2:0] : I[2:0]; the table is 2048, 4, 135, 213, 273, 323, 373, 425; DQS = I[3].
- 24k: index = I[2] ? ~I[1:0] : I[1:0]; the table is 2048, 135, 273, 373; DQS = I[2].
- 16k: index = I[1] ? ~I[0] : I[0]; the table is 116, 365; DQS = I[1].
REQ-019 S2 SHALL compute DQL = (DQLN + {1'b0, Y[12:2]}) mod 4096.
REQ-020 S3 SHALL derive its fields from DQL: DS = DQL[11], DEX = DQL[10:7], DMN = DQL[6:0], DQT = {1, DMN}.
REQ-021 S3 SHALL compute DQMAG = DS ? 0 : ((DQT << 7) >> (14 - DEX)), truncated to 15 bits.
REQ-022 S3 SHALL output DQ = {DQS, DQMAG}.
REQ-023 A RATE change between samples SHALL take effect from the next accepted sample only; in-flight samples SHALL keep their captured RATE.
REQ-024 Simultaneous input accept and output drain with a full pipeline SHALL be sustained without a bubble.

Reset
REQ-025 Asserting reset SHALL immediately clear all stage valid flags.
REQ-026 Reset SHALL force out_valid=0 and DQ=16'h0000.
REQ-027 in_ready SHALL be 1 on the first edge after reset deasserts.
REQ-028 Reset asserted mid-stream SHALL discard all in-flight samples; no stale output SHALL appear after reset is released.

Verification
REQ-029 The bench SHALL cover this case: RATE=1, I=5'h07, Y=0, out_ready=1 -> out_valid rises 3 cycles later with DQ=16'h000A.
REQ-030 The bench SHALL cover this case: RATE=1, I=5'h08, Y=0 -> DQ=16'h800A. Then RATE=1, I=5'h00 -> DQ=16'h0000.
REQ-031 The bench SHALL cover this case: RATE=1, I=5'h07, Y=13'h0800 -> DQ=16'h00A9.
REQ-032 The bench SHALL cover this case: stream 8 samples back-to-back, hold out_ready=0 for 5 cycles mid-stream -> in_ready drops once the 3 stages are full, DQ stays stable, and all 8 results emerge in order.
REQ-033 The bench SHALL cover this case: assert reset with 3 samples in flight -> out_valid=0 and DQ=0 at once, and no result appears after release until new input is given.
REQ-034 The bench SHALL cover this case: sweep all 4 RATE values over every legal I with random Y (544..5120) -> results match the G.726 reference inverse-quantizer vectors, and RATE switching between samples keeps per-sample correctness.
